// File: rtl/vote_result_reader.sv
// Readout controller: closes the poll, steps every candidate's tally with Result
// pulses, captures the display into a table and tracks winner/tie/total.
// Optional total cross-check against exp_total enabled by VOTE_READER_CHECK_EN.
module vote_result_reader #(
  parameter int NUM_CAND   = 15,
  parameter int W          = 12,
  parameter int CLOSE_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] disp,
  input  logic [15:0]  exp_total,
  input  logic [3:0]   rd_idx,
  output logic         Close,
  output logic         Result,
  output logic         busy,
  output logic         done,
  output logic [3:0]   winner,
  output logic [W-1:0] win_count,
  output logic         tie,
  output logic [15:0]  total,
  output logic [W-1:0] rd_tally,
  output logic         mismatch
);

  typedef enum logic [2:0] {S_IDLE, S_CLOSE, S_GAP, S_PULSE, S_SETTLE, S_FINISH} state_t;

  localparam logic [3:0] NC = 4'(NUM_CAND);

  state_t               state, state_n;
  logic [7:0]           cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic                 cap, clr;
  logic [15:0]          tot_n;
  logic [NUM_CAND:1][W-1:0] tally;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 8'd1;
    idx_n   = idx;
    cap     = 1'b0;
    clr     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start) begin
          clr     = 1'b1;
          idx_n   = 4'd1;
          state_n = S_CLOSE;
        end
      end
      S_CLOSE:
        if (cnt == 8'(CLOSE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end
      S_GAP:
        if (cnt == 8'(SETTLE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_PULSE;
        end
      S_PULSE:
        if (cnt == 8'(PULSE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_SETTLE;
        end
      S_SETTLE:
        if (cnt == 8'(SETTLE_CYC - 1)) begin
          cap   = 1'b1;
          cnt_n = '0;
          if (idx == NC) state_n = S_FINISH;
          else begin
            idx_n   = idx + 4'd1;
            state_n = S_PULSE;
          end
        end
      S_FINISH: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign tot_n = total + 16'(disp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Close  <= 1'b0;
      Result <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      Close  <= (state_n == S_CLOSE);
      Result <= (state_n == S_PULSE);
      busy   <= (state_n != S_IDLE) && (state_n != S_FINISH);
      done   <= (state_n == S_FINISH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tally     <= '0;
      winner    <= '0;
      win_count <= '0;
      tie       <= 1'b0;
      total     <= '0;
    end else if (clr) begin
      tally     <= '0;
      winner    <= '0;
      win_count <= '0;
      tie       <= 1'b0;
      total     <= '0;
    end else if (cap) begin
      tally[idx] <= disp;
      total      <= tot_n;
      // Strictly greater wins, so on equal tallies the lowest code is kept.
      if (disp > win_count) begin
        winner    <= idx;
        win_count <= disp;
        tie       <= 1'b0;
      end else if (disp == win_count && disp != '0) begin
        tie <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_tally = '0;
    if (rd_idx != 4'd0 && rd_idx <= NC) rd_tally = tally[rd_idx];
  end

`ifdef VOTE_READER_CHECK_EN
  // Evaluated on the final capture so the flag is already valid during FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     mismatch <= 1'b0;
    else if (clr)                mismatch <= 1'b0;
    else if (cap && idx == NC)   mismatch <= (tot_n != exp_total);
  end
`else
  logic unused_exp;
  assign unused_exp = ^exp_total;
  assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_vote_result_reader.sv
// Directed bench for vote_result_reader with a small vote-core display model.
module tb_vote_result_reader;

  logic        clk, rst, start;
  logic [11:0] disp;
  logic [15:0] exp_total;
  logic [3:0]  rd_idx;
  logic        Close, Result, busy, done, tie, mismatch;
  logic [3:0]  winner;
  logic [11:0] win_count, rd_tally;
  logic [15:0] total;

  vote_result_reader dut (
    .clk(clk), .rst(rst), .start(start), .disp(disp), .exp_total(exp_total),
    .rd_idx(rd_idx), .Close(Close), .Result(Result), .busy(busy), .done(done),
    .winner(winner), .win_count(win_count), .tie(tie), .total(total),
    .rd_tally(rd_tally), .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vote core model: display advances one table entry per Result rising edge.
  logic [11:0] tbl [0:15];
  int          ptr;
  logic        res_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= 0;
      res_q <= 1'b0;
    end else begin
      res_q <= Result;
      if (Close) ptr <= 0;
      else if (Result && !res_q) ptr <= ptr + 1;
    end
  end
  always_comb disp = (ptr >= 1 && ptr <= 15) ? tbl[ptr] : 12'd0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int   close_hi, pulses, badw, overlap, done_cnt, done_cyc, cur_w;
  logic prev_r, busy_c1, mm_c1, mm_done;

  task automatic clear_tbl();
    for (int i = 0; i < 16; i++) tbl[i] = 12'd0;
  endtask

  task automatic run(input int rst_cyc, input bit spur);
    close_hi = 0; pulses = 0; badw = 0; overlap = 0;
    done_cnt = 0; done_cyc = 0; cur_w = 0; prev_r = 1'b0; mm_done = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    busy_c1 = busy;
    mm_c1   = mismatch;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (Close && Result) overlap++;
      if (Close) close_hi++;
      if (Result) cur_w++;
      else if (prev_r) begin
        pulses++;
        if (cur_w != 4) badw++;
        cur_w = 0;
      end
      prev_r = Result;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          mm_done  = mismatch;
        end
      end
      start = spur && (cyc == 10 || cyc == 60);
      if (cyc == rst_cyc) begin
        start = 1'b0;
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_close", Close, 0);
        chk("rst_result", Result, 0);
        chk("rst_busy", busy, 0);
        return;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic load_t1();
    clear_tbl();
    tbl[1] = 12'd12; tbl[5] = 12'd5; tbl[9] = 12'd3;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rd_idx = 4'd0; exp_total = 16'd0;
    clear_tbl();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_close", Close, 0);
    chk("reset_result", Result, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_winner", winner, 0);
    chk("reset_total", total, 0);
    chk("reset_mismatch", mismatch, 0);
    rd_idx = 4'd1;
    chk("reset_rd1", rd_tally, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table 1: clear winner
    load_t1();
    exp_total = 16'd20;
    run(0, 1'b0);
    chk("t1_busy_c1", busy_c1, 1);
    chk("t1_done_cyc", done_cyc, 111);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_close_hi", close_hi, 2);
    chk("t1_pulses", pulses, 15);
    chk("t1_bad_width", badw, 0);
    chk("t1_overlap", overlap, 0);
    chk("t1_winner", winner, 1);
    chk("t1_win_count", win_count, 12);
    chk("t1_tie", tie, 0);
    chk("t1_total", total, 20);
    chk("t1_mismatch", mm_done, 0);
    rd_idx = 4'd5;  #1; chk("t1_rd5", rd_tally, 5);
    rd_idx = 4'd9;  #1; chk("t1_rd9", rd_tally, 3);
    rd_idx = 4'd2;  #1; chk("t1_rd2", rd_tally, 0);

    // Table 2: tie between 3 and 8
    clear_tbl();
    tbl[3] = 12'd7; tbl[8] = 12'd7;
    run(0, 1'b0);
    chk("t2_done_cyc", done_cyc, 111);
    chk("t2_winner", winner, 3);
    chk("t2_win_count", win_count, 7);
    chk("t2_tie", tie, 1);
    chk("t2_total", total, 14);

    // All zero
    clear_tbl();
    run(0, 1'b0);
    chk("z_winner", winner, 0);
    chk("z_win_count", win_count, 0);
    chk("z_tie", tie, 0);
    chk("z_total", total, 0);
    rd_idx = 4'd0;  #1; chk("z_rd0", rd_tally, 0);
    rd_idx = 4'd15; #1; chk("z_rd15", rd_tally, 0);

    // Reset mid-readout, after c1 has been captured
    load_t1();
    run(40, 1'b0);
    rd_idx = 4'd1; #1; chk("rst_rd1", rd_tally, 0);
    rd_idx = 4'd3; #1; chk("rst_rd3", rd_tally, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, 1'b0);
    chk("after_rst_done_cyc", done_cyc, 111);
    chk("after_rst_winner", winner, 1);
    chk("after_rst_total", total, 20);

    // start pulses while busy are ignored
    run(0, 1'b1);
    chk("spur_done_cyc", done_cyc, 111);
    chk("spur_done_cnt", done_cnt, 1);
    chk("spur_pulses", pulses, 15);

    // Total cross-check
    exp_total = 16'd21;
    run(0, 1'b0);
`ifdef VOTE_READER_CHECK_EN
    chk("mm_at_finish", mm_done, 1);
    chk("mm_held", mismatch, 1);
    exp_total = 16'd20;
    run(0, 1'b0);
    chk("mm_cleared_on_start", mm_c1, 0);
    chk("mm_match", mismatch, 0);
`else
    chk("mm_tied_low_finish", mm_done, 0);
    chk("mm_tied_low", mismatch, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vote_result_reader.md
Name: vote_result_reader

Overview:
- Readout controller for the voting machine; sits on the Close/Result/display side of the vote core.
- After polling ends, it closes the poll and steps through every candidate's tally with Result pulses.
- It captures each 12-bit display value into an internal table and computes the winner, tie flag and total votes.
- Host logic reads the captured table through a random-access port.

Parameters:
- NUM_CAND, 15, number of candidates stepped (1..15; candidate codes 1..NUM_CAND).
- W, 12, display/tally width.
- CLOSE_CYC, 2, cycles Close is held high.
- PULSE_CYC, 4, cycles each Result pulse is held high.
- SETTLE_CYC, 3, low cycles after Close or after each Result pulse before disp is sampled.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin readout; sampled only in IDLE.
- disp  in  W  display value from vote core.
- exp_total  in  16  expected ballot count (used only with the optional feature).
- rd_idx  in  4  table read index (candidate code 1..NUM_CAND).
- Close  out  1  poll close strobe to vote core.
- Result  out  1  result step strobe to vote core.
- busy  out  1  readout in progress.
- done  out  1  one-cycle completion pulse.
- winner  out  4  code of the winning candidate (0 = none).
- win_count  out  W  winner's tally.
- tie  out  1  another candidate equals the winner's tally.
- total  out  16  sum of all captured tallies.
- rd_tally  out  W  tally[rd_idx], combinational read.
- mismatch  out  1  total differs from exp_total.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. All outputs are registered except rd_tally.
- Reset values: Close=0, Result=0, busy=0, done=0, winner=0, win_count=0, tie=0, total=0, mismatch=0, all table entries=0, FSM in IDLE.
- Reset mid-operation: aborts immediately. Close and Result drop in the same instant; the table is cleared.
- FSM states: IDLE, CLOSE, GAP, PULSE, SETTLE, FINISH.
- IDLE:
  - busy=0.
  - start=1 at an edge: clear table, winner, win_count, tie, total and mismatch; set idx=1; go to CLOSE with busy=1.
- CLOSE: Close=1 for exactly CLOSE_CYC cycles, then go to GAP.
- GAP: Close=0 for SETTLE_CYC cycles, then go to PULSE.
- PULSE: Result=1 for exactly PULSE_CYC cycles, then go to SETTLE.
- SETTLE:
  - Result=0 for SETTLE_CYC cycles.
  - On the edge ending the last SETTLE cycle, capture tally[idx]<=disp and update the running statistics.
  - If idx==NUM_CAND, go to FINISH; else idx+=1 and go to PULSE.
- FINISH: done=1 and busy=0 for one cycle, then go to IDLE.
- Timing: done is high in cycle L+1 after the start-sampling edge, where L = CLOSE_CYC + SETTLE_CYC + NUM_CAND*(PULSE_CYC+SETTLE_CYC). Defaults give L=110.
- Statistics update at each capture of disp value v:
  - total += v (16-bit; maximum 15*4095 fits, no overflow).
  - If v > win_count: winner=idx, win_count=v, tie=0.
  - Else if v==win_count and v!=0: tie=1, winner unchanged (lowest code kept).
- All-zero tallies: winner=0, win_count=0, tie=0.
- start while busy: ignored. start held high through FINISH starts a new readout in the following IDLE cycle.
- Read port: rd_tally = tally[rd_idx] if 1<=rd_idx<=NUM_CAND, else 0. Readable at any time; returns zeros until captured.
- Close and Result are never high in the same cycle.

Optional Feature:
- Macro: VOTE_READER_CHECK_EN.
- Defined: in FINISH, mismatch is set to (total != exp_total) and holds until the next start or reset.
- Undefined: mismatch is tied 0 and exp_total is ignored.

Test Plan:
- Reset, then start with disp modelled as tally table {c1=12, c5=5, c9=3, others 0}, advancing one entry per Result rising edge:
  - Close high 2 cycles.
  - 15 Result pulses, each 4 cycles wide.
  - done in cycle 111.
  - winner=1, win_count=12, tie=0, total=20.
  - rd_idx=5 gives rd_tally=5.
- Tally table {c3=7, c8=7, others 0} -> winner=3, win_count=7, tie=1, total=14.
- All tallies 0 -> winner=0, win_count=0, tie=0, total=0; rd_idx=0 and rd_idx=15 both give 0.
- Assert rst at cycle 40 of a readout -> Close=0, Result=0, busy=0 immediately; table reads all 0. A new start then completes normally in 111 cycles.
- Pulse start again at cycles 10 and 60 while busy -> no restart; done occurs exactly once at cycle 111.
- With VOTE_READER_CHECK_EN, first table, exp_total=20 -> mismatch=0. Rerun with exp_total=21 -> mismatch=1 from the FINISH cycle until the next start. Without the macro, mismatch stays 0.
